mac_unit: RTL and testbench

- Multi-cycle signed fixed-point multiply/accumulate engine for the MLP datapath.
- Sits directly downstream of the 16-entry register file: it consumes the two read ports (a, b) and writes its result back through the file's write port (cadr, c, rfile_we).
- Iterative shift-add multiplier, one bit per cycle, with an internal saturating accumulator, so MNIST dot products run without extra register traffic.

---
 rtl/mac_unit_pkg.sv | 30 +++
 rtl/mac_unit_if.sv | 32 +++
 rtl/mac_unit_seq_mul.sv | 55 +++++
 rtl/mac_unit.sv | 160 ++++++++++++++++
 tb/tb_mac_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mac_unit_pkg.sv
// rtl/mac_unit_pkg.sv - shared encodings, width defaults and Q-format limits for mac_unit
// Purpose: op/state encodings and default widths used by mac_unit, seq_mul and mac_unit_if.
// Ports:   none (package).
package mac_unit_pkg;

  // Width defaults; REG_W and ADR_W track the register-file word and address widths.
  localparam int REG_W_DEF  = 16;
  localparam int ADR_W_DEF  = 4;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_MAC = 2'b01,
    OP_CLR = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_ACC  = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // Q8.8 write-back saturation limits.
  localparam logic [REG_W_DEF-1:0] Q_MAX = 16'h7FFF;
  localparam logic [REG_W_DEF-1:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/mac_unit_if.sv
// rtl/mac_unit_if.sv - request/response bundle between the register file side and mac_unit
// Purpose: groups the start/op/operand request and the busy/done/write-back response.
// Ports:   master drives start, op, a, b, dst; slave (mac_unit) drives busy, done, cadr, c, rfile_we.
interface mac_unit_if
  import mac_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int ADR_W = ADR_W_DEF
);

  logic             start;
  logic [1:0]       op;
  logic [REG_W-1:0] a;
  logic [REG_W-1:0] b;
  logic [ADR_W-1:0] dst;
  logic             busy;
  logic             done;
  logic [ADR_W-1:0] cadr;
  logic [REG_W-1:0] c;
  logic             rfile_we;

  modport master (
    output start, op, a, b, dst,
    input  busy, done, cadr, c, rfile_we
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, done, cadr, c, rfile_we
  );

endinterface

// File: rtl/mac_unit_seq_mul.sv
// rtl/mac_unit_seq_mul.sv - unsigned shift-add multiplier, one multiplier bit per cycle
// Purpose: W-cycle unsigned multiply; operands captured on start.
// Ports:   clk, rst (sync, active high), start (load operands), mcand, mplier,
//          prod (2W-bit product), valid (high during the final iteration).
module seq_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] prod,
  output logic           valid
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] mc_sh;
  logic [W-1:0]   mp_sh;
  logic [CW-1:0]  cnt;
  logic           run;

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_sh <= '0;
      mp_sh <= '0;
      prod  <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      mc_sh <= {{W{1'b0}}, mcand};
      mp_sh <= mplier;
      prod  <= '0;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      if (mp_sh[0]) begin
        prod <= prod + mc_sh;
      end
      mc_sh <= mc_sh << 1;
      mp_sh <= mp_sh >> 1;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        run <= 1'b0;
      end
    end
  end

  // Raised in the last iteration so the caller can leave its wait state on
  // the same edge that writes the final partial sum; prod is complete after it.
  assign valid = run && (cnt == LAST);

endmodule

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed Q-format multiply/accumulate engine with register-file write-back
// Purpose: MUL/MAC/CLR/RD on a saturating accumulator; result written back as Q(REG_W-FRAC_W).FRAC_W.
// Ports:   clk, rst (sync, active high), bus (mac_unit_if.slave: start, op, a, b, dst in;
//          busy, done, cadr, c, rfile_we out).
// Config:  MAC_ROUND_EN defined -> round half up before the write-back shift; else truncate.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int ADR_W  = ADR_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mac_unit_if.slave  bus
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   R_HI    = (ACC_W+1)'(2**(REG_W-1) - 1);
  localparam logic signed [ACC_W:0]   R_LO    = (ACC_W+1)'(-(2**(REG_W-1)));
  localparam logic [REG_W-1:0]        SAT_HI  = {1'b0, {(REG_W-1){1'b1}}};
  localparam logic [REG_W-1:0]        SAT_LO  = {1'b1, {(REG_W-1){1'b0}}};
`ifdef MAC_ROUND_EN
  localparam logic signed [ACC_W:0]   RND_HALF = (ACC_W+1)'(1) << (FRAC_W - 1);
`endif

  state_e state, state_nxt;

  op_e                      op_q;
  logic [ADR_W-1:0]         dst_q;
  logic                     sign_q;
  logic signed [ACC_W-1:0]  acc;
  logic [REG_W-1:0]         c_q;
  logic [ADR_W-1:0]         cadr_q;
  logic                     we_q;
  logic                     done_q;

  logic [REG_W-1:0]         a_mag, b_mag;
  logic                     mul_start, mul_last;
  logic [2*REG_W-1:0]       prod;

  logic signed [2*REG_W-1:0] prod_s, p;
  logic signed [ACC_W-1:0]   p_ext, sum, acc_mac;
  logic                      ovf;
  logic signed [ACC_W:0]     rnd, shf;
  logic [REG_W-1:0]          r;

  // Magnitudes as unsigned REG_W values: the most negative input keeps its
  // bit pattern, which read unsigned is exactly its magnitude.
  assign a_mag = bus.a[REG_W-1] ? REG_W'(-bus.a) : bus.a;
  assign b_mag = bus.b[REG_W-1] ? REG_W'(-bus.b) : bus.b;

  assign mul_start = (state == S_IDLE) && bus.start &&
                     ((op_e'(bus.op) == OP_MUL) || (op_e'(bus.op) == OP_MAC));

  seq_mul #(.W(REG_W)) u_seq_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .mcand  (a_mag),
    .mplier (b_mag),
    .prod   (prod),
    .valid  (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (mul_start) state_nxt = S_CALC;
          else           state_nxt = S_WB;
        end
      end
      S_CALC:  if (mul_last) state_nxt = S_ACC;
      S_ACC:   state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    prod_s  = signed'(prod);
    p       = sign_q ? -prod_s : prod_s;
    p_ext   = ACC_W'(p);
    sum     = acc + p_ext;
    // Overflow only when both addends share a sign the sum does not.
    ovf     = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    acc_mac = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;

    // One guard bit so the rounding increment cannot wrap a saturated acc.
    rnd = (ACC_W+1)'(acc);
`ifdef MAC_ROUND_EN
    rnd = rnd + RND_HALF;
`endif
    shf = rnd >>> FRAC_W;
    if (shf > R_HI) begin
      r = SAT_HI;
    end else if (shf < R_LO) begin
      r = SAT_LO;
    end else begin
      r = shf[REG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_MUL;
      dst_q  <= '0;
      sign_q <= 1'b0;
      acc    <= '0;
      c_q    <= '0;
      cadr_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= op_e'(bus.op);
            dst_q  <= bus.dst;
            sign_q <= bus.a[REG_W-1] ^ bus.b[REG_W-1];
            if (op_e'(bus.op) == OP_CLR) begin
              acc <= '0;
            end
          end
        end
        S_ACC: begin
          acc <= (op_q == OP_MUL) ? p_ext : acc_mac;
        end
        S_WB: begin
          c_q    <= r;
          cadr_q <= dst_q;
          done_q <= 1'b1;
          we_q   <= (op_q != OP_CLR);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.cadr     = cadr_q;
  assign bus.c        = c_q;
  assign bus.rfile_we = we_q;

endmodule

// File: tb/tb_mac_unit.sv
// tb/tb_mac_unit.sv - directed self-checking bench for mac_unit
module tb_mac_unit;
  import mac_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] exp_r1, exp_r2;

  always #5 clk = ~clk;

  mac_unit_if bus ();

  mac_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; issues one request and checks its write-back.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [3:0] d, input int exp_lat,
                        input logic [15:0] exp_c, input logic exp_we);
    int lat;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    bus.dst   = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.dst   = 4'($urandom);
    check({tag, "/busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/c"}, 32'(bus.c), 32'(exp_c));
    check({tag, "/cadr"}, 32'(bus.cadr), 32'(d));
    check({tag, "/we"}, 32'(bus.rfile_we), 32'(exp_we));
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/we_pulse"}, 32'(bus.rfile_we), 32'd0);
  endtask

  initial begin
    int   wr_seen, pulses, first_k, last_k, hi_cycles, k;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    bus.dst   = '0;
`ifdef MAC_ROUND_EN
    exp_r1 = 16'h0001;
    exp_r2 = 16'h0000;
`else
    exp_r1 = 16'h0000;
    exp_r2 = 16'hFFFF;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/we", 32'(bus.rfile_we), 32'd0);
    check("rst/c", 32'(bus.c), 32'd0);
    check("rst/cadr", 32'(bus.cadr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("t1_mul", OP_MUL, 16'h0200, 16'h0300, 4'd5, 18, 16'h0600, 1'b1);

    run_op("t2_clr", OP_CLR, 16'h1234, 16'h5678, 4'd2, 1, 16'h0000, 1'b0);
    run_op("t2_mac1", OP_MAC, 16'h0100, 16'hFF00, 4'd6, 18, 16'hFF00, 1'b1);
    run_op("t2_mac2", OP_MAC, 16'h0080, 16'h0080, 4'd6, 18, 16'hFF40, 1'b1);

    run_op("t3_clr", OP_CLR, 16'h0000, 16'h0000, 4'd0, 1, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++)
      run_op($sformatf("t3_pos%0d", i), OP_MAC, 16'h7FFF, 16'h7FFF, 4'd7, 18, 16'h7FFF, 1'b1);
    run_op("t3_clr2", OP_CLR, 16'h0000, 16'h0000, 4'd0, 1, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++)
      run_op($sformatf("t3_neg%0d", i), OP_MAC, 16'h8000, 16'h7FFF, 4'd8, 18, 16'h8000, 1'b1);
    run_op("t3_minsq", OP_MUL, 16'h8000, 16'h8000, 4'd1, 18, 16'h7FFF, 1'b1);
    run_op("t3_minmac", OP_MAC, 16'h8000, 16'h7FFF, 4'd1, 18, 16'h0080, 1'b1);

    run_op("t4_rnd_pos", OP_MUL, 16'h0001, 16'h0080, 4'd3, 18, exp_r1, 1'b1);
    run_op("t4_rnd_neg", OP_MUL, 16'hFFFF, 16'h0080, 4'd3, 18, exp_r2, 1'b1);

    run_op("t5_pre", OP_MUL, 16'h0100, 16'h0300, 4'd4, 18, 16'h0300, 1'b1);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 16'h0200;
    bus.b     = 16'h0300;
    bus.dst   = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wr_seen = 0;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      if (bus.rfile_we || bus.done) wr_seen++;
      if (j == 4) bus.start = 1'b1;
      if (j == 5) bus.start = 1'b0;
      if (j == 6) check("t5/busy_mid", 32'(bus.busy), 32'd1);
      if (j == 7) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5/busy", 32'(bus.busy), 32'd0);
    check("t5/c", 32'(bus.c), 32'd0);
    check("t5/cadr", 32'(bus.cadr), 32'd0);
    for (int j = 0; j < 25; j++) begin
      @(posedge clk); #1;
      if (bus.rfile_we || bus.done) wr_seen++;
    end
    check("t5/no_write", 32'(wr_seen), 32'd0);
    run_op("t5_rd", OP_RD, 16'h0000, 16'h0000, 4'd3, 1, 16'h0000, 1'b1);

    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 16'h0200;
    bus.b     = 16'h0300;
    bus.dst   = 4'd10;
    pulses = 0; first_k = 0; last_k = 0; hi_cycles = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (bus.rfile_we) begin
        hi_cycles++;
        if (pulses == 0) first_k = j;
        last_k = j;
        pulses++;
      end
    end
    bus.start = 1'b0;
    check("t6/mul_pulses", 32'(pulses), 32'd2);
    check("t6/mul_first", 32'(first_k), 32'd19);
    check("t6/mul_gap", 32'(last_k - first_k), 32'd19);
    k = 0;
    while (bus.busy && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6/drain", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    bus.start = 1'b1;
    bus.op    = OP_RD;
    pulses = 0; hi_cycles = 0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      if (bus.rfile_we) begin
        hi_cycles++;
        if (j % 2 == 0) pulses++;
      end
    end
    bus.start = 1'b0;
    check("t6/rd_pulses", 32'(pulses), 32'd5);
    check("t6/rd_hi", 32'(hi_cycles), 32'd5);
    @(posedge clk); #1;
    check("t6/rd_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
